// File: rtl/enc_rate_ctrl.sv
// Symbol-rate scheduler: produces per-bit and per-symbol clock enables for the
// convolutional encoder and serializer from a loadable divide ratio and frame length.
module enc_rate_ctrl #(
  parameter int DIV_W   = 8,
  parameter int FRAME_W = 8,
  parameter int RATE_N  = 2,
  parameter int PH_W    = $clog2(RATE_N)
) (
  input  logic               clk_sig,
  input  logic               reset_sig,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [FRAME_W-1:0] cfg_len,
  input  logic               start_sig,
  input  logic               stop_sig,
  output logic               in_tick,
  output logic               out_tick,
  output logic [PH_W-1:0]    out_phase,
  output logic               busy_sig,
  output logic               done_sig
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATE_N - 1);

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_r;
  logic [FRAME_W:0]   len_r;
  logic [DIV_W-1:0]   div_cnt;
  logic [FRAME_W-1:0] bit_cnt;
  logic               cfg_hs;
  logic               sym_wrap;
  logic               bit_wrap;
  logic               frame_end;

  function automatic logic [DIV_W-1:0] sanitize_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  // A zero length means a full 2^FRAME_W-bit frame, hence the extra bit.
  function automatic logic [FRAME_W:0] sanitize_len(input logic [FRAME_W-1:0] l);
    return (l == '0) ? {1'b1, {FRAME_W{1'b0}}} : {1'b0, l};
  endfunction

  assign cfg_hs    = cfg_valid && (state == IDLE);
  assign sym_wrap  = (state == RUN) && (div_cnt == div_r - 1'b1);
  assign bit_wrap  = sym_wrap && (out_phase == PH_LAST);
  assign frame_end = bit_wrap && ({1'b0, bit_cnt} == len_r - 1'b1);

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) state <= IDLE;
    else           state <= state_nxt;
  end

  // Stop wins over completion when both land on the same edge.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_sig) state_nxt = RUN;
      RUN:     if (stop_sig) state_nxt = IDLE;
               else if (frame_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      div_r <= DIV_W'(1);
      len_r <= (FRAME_W+1)'(1);
    end else if (cfg_hs) begin
      div_r <= sanitize_div(cfg_div);
      len_r <= sanitize_len(cfg_len);
    end
  end

  // Counters only advance while staying in RUN; every other transition clears them.
  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      div_cnt   <= '0;
      out_phase <= '0;
      bit_cnt   <= '0;
    end else if (state == RUN && state_nxt == RUN) begin
      div_cnt <= sym_wrap ? '0 : div_cnt + 1'b1;
      if (sym_wrap) out_phase <= bit_wrap ? '0 : out_phase + 1'b1;
      if (bit_wrap) bit_cnt <= bit_cnt + 1'b1;
    end else begin
      div_cnt   <= '0;
      out_phase <= '0;
      bit_cnt   <= '0;
    end
  end

  assign out_tick  = (state == RUN) && (div_cnt == '0);
  assign in_tick   = out_tick && (out_phase == '0);
  assign busy_sig  = (state == RUN);
  assign done_sig  = (state == DONE);
  assign cfg_ready = (state == IDLE);

endmodule

// File: tb/tb_enc_rate_ctrl.sv
// Directed bench for enc_rate_ctrl: expected strobe events are queued by the
// stimulus and matched by a monitor whenever the DUT raises a strobe.
module tb_enc_rate_ctrl;
  localparam int DIV_W   = 8;
  localparam int FRAME_W = 8;
  localparam int RATE_N  = 2;
  localparam int PH_W    = 1;

  logic               clk_sig = 1'b0;
  logic               reset_sig = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [DIV_W-1:0]   cfg_div = '0;
  logic [FRAME_W-1:0] cfg_len = '0;
  logic               start_sig = 1'b0;
  logic               stop_sig = 1'b0;
  logic               in_tick;
  logic               out_tick;
  logic [PH_W-1:0]    out_phase;
  logic               busy_sig;
  logic               done_sig;

  enc_rate_ctrl #(.DIV_W(DIV_W), .FRAME_W(FRAME_W), .RATE_N(RATE_N)) dut (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_len(cfg_len), .start_sig(start_sig), .stop_sig(stop_sig),
    .in_tick(in_tick), .out_tick(out_tick), .out_phase(out_phase), .busy_sig(busy_sig),
    .done_sig(done_sig)
  );

  always #5 clk_sig = ~clk_sig;

  typedef struct {
    int              rel;
    logic            ot;
    logic            it;
    logic [PH_W-1:0] ph;
    logic            dn;
    logic            bz;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  cyc = 0;
  int  t0 = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk_sig) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (rel cycle %0d)", name, act, req, cyc - t0);
    end
  endtask

  // Monitor: each strobe cycle consumes one expected event.
  always @(negedge clk_sig) begin
    if (out_tick || in_tick || done_sig) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got ot=%b it=%b dn=%b at rel cycle %0d, expected none",
                 out_tick, in_tick, done_sig, cyc - t0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("event_cycle", 32'(cyc - t0), 32'(mon_ev.rel));
        check("event_flags", 32'({out_tick, in_tick, out_phase, done_sig, busy_sig}),
              32'({mon_ev.ot, mon_ev.it, mon_ev.ph, mon_ev.dn, mon_ev.bz}));
      end
    end
  end

  task automatic push(input int rel, input logic ot, input logic it, input logic [PH_W-1:0] ph,
                      input logic dn, input logic bz);
    ev_t e;
    e.rel = rel; e.ot = ot; e.it = it; e.ph = ph; e.dn = dn; e.bz = bz;
    exp_q.push_back(e);
  endtask

  // Symbol k of the frame ticks at cycle 1 + k*div; done follows the last RUN cycle.
  task automatic push_frame(input int d, input int l);
    for (int b = 0; b < l; b++)
      for (int p = 0; p < RATE_N; p++)
        push(1 + (b * RATE_N + p) * d, 1'b1, p == 0, PH_W'(p), 1'b0, 1'b1);
    push(l * RATE_N * d + 1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic load_cfg(input logic [DIV_W-1:0] d, input logic [FRAME_W-1:0] l);
    @(posedge clk_sig); #1;
    cfg_valid = 1'b1; cfg_div = d; cfg_len = l;
    @(posedge clk_sig); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic start_frame(input logic with_cfg, input logic [DIV_W-1:0] d,
                             input logic [FRAME_W-1:0] l);
    @(posedge clk_sig); #1;
    start_sig = 1'b1;
    if (with_cfg) begin
      cfg_valid = 1'b1; cfg_div = d; cfg_len = l;
    end
    t0 = cyc;
    @(posedge clk_sig); #1;
    start_sig = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_rel(input int k);
    do @(negedge clk_sig); while (cyc - t0 < k);
  endtask

  task automatic check_idle(input string name);
    check(name, 32'({busy_sig, in_tick, out_tick, done_sig, cfg_ready, out_phase}), 32'(6'b000010));
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic default_frame(input string tag);
    push(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    start_frame(1'b0, '0, '0);
    wait_rel(4);
    check_idle({tag, "_idle_after"});
    check_drained({tag, "_drained"});
  endtask

  initial begin
    #2 reset_sig = 1'b1;
    @(negedge clk_sig);
    check_idle("reset_state");
    @(posedge clk_sig); #1;
    reset_sig = 1'b0;

    default_frame("default");

    // div=3, len=2
    load_cfg(8'd3, 8'd2);
    push(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push(7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push(13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    start_frame(1'b0, '0, '0);
    wait_rel(12);
    check("busy_last_run_cycle", 32'({busy_sig, cfg_ready}), 32'(2'b10));
    wait_rel(13);
    check("done_cycle_ready", 32'({busy_sig, cfg_ready}), 32'(2'b00));
    wait_rel(14);
    check_idle("ready_after_done");
    check_drained("div3_drained");

    // Config on the same edge as start overrides an earlier div=5 load.
    load_cfg(8'd5, 8'd1);
    push(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push(5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    start_frame(1'b1, 8'd2, 8'd1);
    wait_rel(6);
    check_idle("samedge_idle_after");
    check_drained("samedge_drained");

    // Abort at cycle 4 of a div=3, len=4 frame; config offered during RUN is ignored.
    load_cfg(8'd3, 8'd4);
    push(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    start_frame(1'b0, '0, '0);
    cfg_valid = 1'b1; cfg_div = 8'd1; cfg_len = 8'd1;
    wait_rel(3);
    @(posedge clk_sig); #1;
    stop_sig = 1'b1;
    cfg_valid = 1'b0;
    @(posedge clk_sig); #1;
    stop_sig = 1'b0;
    wait_rel(5);
    check_idle("stop_idle");
    wait_rel(8);
    check_drained("stop_no_done");
    push_frame(3, 4);
    start_frame(1'b0, '0, '0);
    wait_rel(26);
    check_idle("after_stop_run_idle");
    check_drained("after_stop_run_drained");

    // Zero config means div=1, len=256.
    load_cfg(8'd0, 8'd0);
    push_frame(1, 256);
    start_frame(1'b0, '0, '0);
    wait_rel(512);
    check("zero_cfg_last_busy", 32'({busy_sig, out_tick}), 32'(2'b11));
    wait_rel(514);
    check_idle("zero_cfg_idle_after");
    check_drained("zero_cfg_drained");

    // Reset mid-frame, then the default frame must reappear.
    push(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    start_frame(1'b0, '0, '0);
    wait_rel(2);
    @(posedge clk_sig); #1;
    reset_sig = 1'b1;
    #1;
    check_idle("reset_async");
    repeat (2) @(posedge clk_sig);
    #1 reset_sig = 1'b0;
    check_drained("reset_drained");
    default_frame("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/enc_rate_ctrl.md
# enc_rate_ctrl

Programmable symbol-rate scheduler for the convolutional encoder datapath. Holds a runtime-loadable divide ratio and frame length. On a start command it produces single-cycle enable strobes: one `in_tick` per input bit and `RATE_N` `out_tick`s per input bit. It replaces fixed-ratio clock division so the encoder and its serializer run from `clk_sig` with clock enables. It sits between the top-level control and the encoder/serializer enables, and reports `busy_sig` and `done_sig` to the frame controller.

## Interface
- `DIV_W`, 8, width of the divide ratio (clk_sig cycles per output symbol).
- `FRAME_W`, 8, width of the frame length (input bits per frame).
- `RATE_N`, 2, output symbols per input bit (code rate 1/RATE_N); legal range 2..8.
- `PH_W`, `$clog2(RATE_N)`, width of `out_phase` (derived; do not override).

Ports:
- `clk_sig`  in  1  system clock; all state changes on its rising edge.
- `reset_sig`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  config offer; accepted when `cfg_valid && cfg_ready` at a clock edge.
- `cfg_ready`  out  1  high exactly when the FSM is in IDLE.
- `cfg_div`  in  DIV_W  cycles per symbol; 0 is treated as 1.
- `cfg_len`  in  FRAME_W  bits per frame; 0 is treated as 2^FRAME_W.
- `start_sig`  in  1  begin a frame; honoured only in IDLE.
- `stop_sig`  in  1  abort the frame; honoured only in RUN.
- `in_tick`  out  1  strobe at the start of each input-bit period.
- `out_tick`  out  1  strobe at the start of each output-symbol period.
- `out_phase`  out  PH_W  index of the current symbol within its bit (0..RATE_N-1).
- `busy_sig`  out  1  high while in RUN.
- `done_sig`  out  1  one-cycle pulse when a frame completes normally.

## Operation
- Registers: `div_r` and `len_r` (config), `div_cnt` (DIV_W), `out_phase` (PH_W), `bit_cnt` (FRAME_W), and the FSM state.
- Reset values:
  - state IDLE, so `cfg_ready`=1.
  - `div_r`=1, `len_r`=1.
  - All counters 0.
  - `in_tick`, `out_tick`, `busy_sig`, `done_sig` all 0; `out_phase`=0.
- Config load: on a handshake, `div_r` and `len_r` take the sanitised values (0 mapped as defined above). Config is held until the next handshake.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE→RUN when `start_sig`=1. On that edge all counters clear. If `cfg_valid` is high on the same edge, the frame uses the newly loaded values.
  - RUN: `div_cnt` increments every cycle.
    - When `div_cnt`==`div_r`-1 it wraps to 0 and `out_phase` increments.
    - When `out_phase`==RATE_N-1 at that wrap, `out_phase` returns to 0 and `bit_cnt` increments.
  - RUN→DONE on the wrap where `bit_cnt`==`len_r`-1 and `out_phase`==RATE_N-1.
  - RUN→IDLE when `stop_sig`=1. `stop_sig` has priority over completion on the same edge. Counters clear and no `done_sig` is produced.
  - DONE→IDLE unconditionally after one cycle.
- Decoded outputs (from registered state; no input-to-output combinational paths):
  - `out_tick` = RUN && `div_cnt`==0.
  - `in_tick` = `out_tick` && `out_phase`==0.
  - `busy_sig` = RUN.
  - `done_sig` = DONE.
  - `cfg_ready` = IDLE.
- Ignored inputs: `start_sig` outside IDLE; `stop_sig` outside RUN; `cfg_valid` outside IDLE (no handshake, config unchanged).
- Comparisons on `bit_cnt` use FRAME_W+1 bits internally, so `len_r`=2^FRAME_W is exact.

## Timing
- Cycle 0 is the cycle in which `start_sig` is sampled.
- The first `in_tick` and `out_tick` occur in cycle 1 (latency 1).
- `out_tick` period is `div_r` cycles; `in_tick` period is RATE_N·`div_r` cycles.
- With `div_r`=1, `out_tick` stays high continuously through RUN.
- RUN lasts exactly `len_r`·RATE_N·`div_r` cycles (cycles 1..T).
- `done_sig` is high in cycle T+1; `cfg_ready` is high again from cycle T+2.
- A back-to-back `start_sig` is accepted earliest in cycle T+2.
- Abort: `stop_sig` in cycle k means `busy_sig`=0 and all strobes are 0 from cycle k+1.
- Asserting `reset_sig` mid-frame clears all outputs asynchronously. Frames do not resume after reset.

## Test plan
- Reset then `start_sig` with default config (div=1, len=1, RATE_N=2):
  - `out_tick` in cycles 1–2, `in_tick` in cycle 1 only, `out_phase` 0,1.
  - `done_sig` in cycle 3.
- Load div=3, len=2, then start:
  - `out_tick` at cycles 1,4,7,10; `in_tick` at 1,7.
  - `busy_sig` high for cycles 1..12; `done_sig` in cycle 13 only.
- Config and start on the same edge (div=2, len=1) after a prior div=5 config: run uses div=2, so `out_tick` at cycles 1,3 and `done_sig` at cycle 5.
- `stop_sig` at cycle 4 of a div=3, len=4 run:
  - `busy_sig`=0 and strobes=0 from cycle 5; no `done_sig`; `cfg_ready`=1 at cycle 5.
  - `cfg_valid` during RUN leaves config unchanged on the next run.
- cfg_div=0 and cfg_len=0 (FRAME_W=8): treated as div=1, len=256, giving exactly 512 `out_tick`s and `done_sig` at cycle 513.
- `reset_sig` pulsed mid-frame:
  - Outputs go to 0 immediately; `cfg_ready`=1.
  - `div_r` returns to 1 and `len_r` to 1.
  - A following start behaves as the first scenario.
